control_ingress_unit: RTL

- Parametrised successor to the controller front end.
- Generalises the LA-override/pad-enable logic to NUM_INPUTS control inputs and NUM_OUTPUTS status outputs.
- Replaces fixed 3-sample AND/OR qualification with a per-input programmable glitch filter plus edge pulses.
- Adds a same-clock command capture register with valid/ready handshake and sticky overrun.
- Sits between the user IO/LA pins and system_controller; all logic on one clock.

---
 rtl/ctrl_ingress_pkg.sv | 27 ++
 rtl/input_glitch_filter.sv | 54 +++++
 rtl/control_ingress_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/ctrl_ingress_pkg.sv
// Shared helpers for the control ingress unit: LA field offsets and filter counter sizing.
package ctrl_ingress_pkg;

    // LA bus layout: [in_oeb | in_val | out_oeb | out_val], lowest field first.
    function automatic int unsigned in_oeb_base();
        return 0;
    endfunction

    function automatic int unsigned in_val_base(input int unsigned num_inputs);
        return num_inputs;
    endfunction

    function automatic int unsigned out_oeb_base(input int unsigned num_inputs);
        return 2 * num_inputs;
    endfunction

    function automatic int unsigned out_val_base(input int unsigned num_inputs,
                                                 input int unsigned num_outputs);
        return 2 * num_inputs + num_outputs;
    endfunction

    // Counter only ever reaches depth-1 before clearing, so depth+1 states is ample.
    function automatic int unsigned filter_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/input_glitch_filter.sv
// Single-input ingress path: input register, 2-flop synchroniser, glitch filter and edge pulses.
module input_glitch_filter
    import ctrl_ingress_pkg::*;
#(
    parameter int unsigned FILTER_DEPTH = 3,
    parameter logic        RESET_VALUE  = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic src,
    output logic filtered,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CW       = filter_cnt_width(FILTER_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_DEPTH - 1);

    logic          src_q;
    logic          sync_1;
    logic          sync_2;
    logic          filt_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= RESET_VALUE;
            sync_1     <= RESET_VALUE;
            sync_2     <= RESET_VALUE;
            filtered   <= RESET_VALUE;
            filt_prev  <= RESET_VALUE;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            src_q      <= src;
            sync_1     <= src_q;
            sync_2     <= sync_1;
            filt_prev  <= filtered;
            rise_pulse <= filtered & ~filt_prev;
            fall_pulse <= ~filtered & filt_prev;
            // A new level is accepted only after FILTER_DEPTH consecutive differing samples.
            if (sync_2 == filtered) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filtered <= sync_2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/control_ingress_unit.sv
// Front end between user IO/LA pins and the system controller: pad muxing, filtered inputs, command capture.
module control_ingress_unit
    import ctrl_ingress_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 3,
    parameter int unsigned NUM_OUTPUTS  = 1,
    parameter int unsigned FILTER_DEPTH = 3,
    parameter int unsigned CMD_WIDTH    = 32,
    parameter int unsigned LATCH_IDX    = 1,
    parameter logic [NUM_INPUTS-1:0]  IN_RESET_VALUES = NUM_INPUTS'(1),
    parameter logic [NUM_OUTPUTS-1:0] OUT_OEB_DEFAULT = '0
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [2*NUM_INPUTS+2*NUM_OUTPUTS-1:0]    la_data_in,
    input  logic [2*NUM_INPUTS+2*NUM_OUTPUTS-1:0]    la_oenb,
    input  logic [NUM_INPUTS-1:0]                    io_in,
    output logic [NUM_INPUTS-1:0]                    io_in_oeb,
    output logic [NUM_INPUTS-1:0]                    filtered,
    output logic [NUM_INPUTS-1:0]                    rise_pulse,
    output logic [NUM_INPUTS-1:0]                    fall_pulse,
    input  logic [NUM_OUTPUTS-1:0]                   core_status,
    output logic [NUM_OUTPUTS-1:0]                   io_out,
    output logic [NUM_OUTPUTS-1:0]                   io_out_oeb,
    input  logic [CMD_WIDTH-1:0]                     cmd_in,
    output logic [CMD_WIDTH-1:0]                     cmd_data,
    output logic                                     cmd_valid,
    input  logic                                     cmd_ready,
    output logic                                     cmd_overrun,
    input  logic                                     overrun_clr
);

    localparam int unsigned IN_OEB_BASE  = in_oeb_base();
    localparam int unsigned IN_VAL_BASE  = in_val_base(NUM_INPUTS);
    localparam int unsigned OUT_OEB_BASE = out_oeb_base(NUM_INPUTS);
    localparam int unsigned OUT_VAL_BASE = out_val_base(NUM_INPUTS, NUM_OUTPUTS);

    logic [NUM_INPUTS-1:0]  src_c;
    logic [NUM_INPUTS-1:0]  in_oeb_nxt_c;
    logic [NUM_OUTPUTS-1:0] out_oeb_nxt_c;
    logic [NUM_OUTPUTS-1:0] out_val_nxt_c;
    logic                   latch_edge_c;
    logic                   accept_c;

    // Per-input LA override muxes and filter instances.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign in_oeb_nxt_c[i] = la_oenb[IN_OEB_BASE + i] ? 1'b1 : la_data_in[IN_OEB_BASE + i];
        assign src_c[i]        = la_oenb[IN_VAL_BASE + i] ? io_in[i] : la_data_in[IN_VAL_BASE + i];

        input_glitch_filter #(
            .FILTER_DEPTH (FILTER_DEPTH),
            .RESET_VALUE  (IN_RESET_VALUES[i])
        ) u_filter (
            .clock      (clock),
            .reset_n    (reset_n),
            .src        (src_c[i]),
            .filtered   (filtered[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
        assign out_oeb_nxt_c[j] = la_oenb[OUT_OEB_BASE + j] ? OUT_OEB_DEFAULT[j]
                                                             : la_data_in[OUT_OEB_BASE + j];
        assign out_val_nxt_c[j] = la_oenb[OUT_VAL_BASE + j] ? core_status[j]
                                                             : la_data_in[OUT_VAL_BASE + j];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_in_oeb  <= '1;
            io_out     <= '0;
            io_out_oeb <= OUT_OEB_DEFAULT;
        end else begin
            io_in_oeb  <= in_oeb_nxt_c;
            io_out     <= out_val_nxt_c;
            io_out_oeb <= out_oeb_nxt_c;
        end
    end

    assign latch_edge_c = rise_pulse[LATCH_IDX];
    assign accept_c     = cmd_valid & cmd_ready;

    // Single-entry command holding register; an edge may refill it in the same cycle it drains.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            cmd_overrun <= 1'b0;
        end else begin
            if (latch_edge_c && (!cmd_valid || cmd_ready)) begin
                cmd_data  <= cmd_in;
                cmd_valid <= 1'b1;
            end else if (accept_c) begin
                cmd_valid <= 1'b0;
            end

            if (latch_edge_c && cmd_valid && !cmd_ready) begin
                cmd_overrun <= 1'b1;
            end else if (overrun_clr) begin
                cmd_overrun <= 1'b0;
            end
        end
    end

endmodule
